// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase-duration timer: latches a phase length in seconds, counts it out on clk,
// and pulses finished once per phase so the traffic controller advances exactly one state.
module phase_timer #(
  parameter int CLK_HZ = 10000,
  parameter int SEC_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_general,
  input  logic [SEC_W-1:0] secondsToCount,
  output logic             finished,
  output logic [SEC_W-1:0] seconds_left,
  output logic             busy
);

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, DONE, LATCH, RUN} state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [SEC_W-1:0]   n_q, n_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DONE;
      tick_q    <= '0;
      sec_cnt_q <= '0;
      n_q       <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      sec_cnt_q <= sec_cnt_d;
      n_q       <= n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    sec_cnt_d = sec_cnt_q;
    n_d       = n_q;
    case (state_q)
      IDLE: begin
        tick_d    = '0;
        sec_cnt_d = '0;
        state_d   = DONE;
      end
      DONE: begin
        tick_d    = '0;
        sec_cnt_d = '0;
        state_d   = LATCH;
      end
      LATCH: begin
        n_d       = secondsToCount;
        tick_d    = '0;
        sec_cnt_d = '0;
        state_d   = (secondsToCount != '0) ? RUN : DONE;
      end
      RUN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          // last second of the phase: expire instead of incrementing past n_q
          if (sec_cnt_q == n_q - SEC_W'(1)) begin
            sec_cnt_d = '0;
            state_d   = DONE;
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // disable parks the timer from any state and discards a partial phase
    if (!enable_general) begin
      state_d   = IDLE;
      tick_d    = '0;
      sec_cnt_d = '0;
    end
  end

  always_comb begin
    finished     = (state_q == DONE);
    busy         = (state_q == LATCH) || (state_q == RUN);
    seconds_left = '0;
    if (state_q == LATCH) seconds_left = secondsToCount;
    else if (state_q == RUN) seconds_left = n_q - sec_cnt_q;
  end

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - randomized and directed bench for phase_timer against a position-in-phase model.
module tb_phase_timer;

  localparam int HZ  = 4;
  localparam int SW  = 6;
  localparam int LOG = 300;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable_general = 1'b0;
  logic [SW-1:0] stc = '0;
  logic          finished;
  logic [SW-1:0] seconds_left;
  logic          busy;

  phase_timer #(.CLK_HZ(HZ), .SEC_W(SW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_general (enable_general),
    .secondsToCount (stc),
    .finished       (finished),
    .seconds_left   (seconds_left),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic fin_log [0:LOG-1];
  logic [SW+1:0] obs, exp_v;

  // Model: m_idle, or pos = cycles since the last finished pulse, m_n = latched phase length
  bit m_idle = 0;
  int pos = 0;
  int m_n = 0;

  function automatic logic [SW+1:0] model_out();
    if (!reset_n) return {2'b10, SW'(0)};
    if (m_idle)   return '0;
    if (pos == 0) return {2'b10, SW'(0)};
    if (pos == 1) return {2'b01, stc};
    return {2'b01, SW'(m_n - (pos - 2) / HZ)};
  endfunction

  task automatic model_advance();
    if (!enable_general) m_idle = 1;
    else if (m_idle) begin m_idle = 0; pos = 0; end
    else if (pos == 0) pos = 1;
    else if (pos == 1) begin m_n = int'(stc); pos = (stc == 0) ? 0 : 2; end
    else if (pos - 1 == m_n * HZ) pos = 0;
    else pos++;
  endtask

  task automatic model_reset();
    m_idle = 0; pos = 0; m_n = 0;
  endtask

  task automatic tick_cycle();
    #1;
    obs   = {finished, busy, seconds_left};
    exp_v = model_out();
    if (cyc < LOG) fin_log[cyc] = finished;
    @(posedge clk);
    if (reset_n) model_advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < LOG; i++) fin_log[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({finished, busy, seconds_left} !== {2'b10, SW'(0)}) begin
      miscompares++;
      $display("FAIL reset got=%h exp=%h", {finished, busy, seconds_left}, {2'b10, SW'(0)});
    end
  endtask

  task automatic test_basic_period();
    int npulse;
    enable_general = 1'b1; stc = 6'd3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", cyc - 1, obs, exp_v);
      end
    end
    npulse = 0;
    for (int i = 1; i < 14; i++) npulse += fin_log[i];
    vectors++;
    if (fin_log[0] !== 1'b1 || fin_log[14] !== 1'b1 || npulse != 0) begin
      miscompares++;
      $display("FAIL basic_pulses got c0=%b c14=%b mid=%0d exp c0=1 c14=1 mid=0", fin_log[0], fin_log[14], npulse);
    end
  endtask

  task automatic test_zero_phase();
    enable_general = 1'b1; stc = 6'd0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick_cycle();
      vectors++;
      if (obs !== exp_v || obs[SW+1] !== ((i % 2) == 0)) begin
        miscompares++;
        $display("FAIL zero cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_mid_change();
    int npulse;
    enable_general = 1'b1; stc = 6'd3;
    do_reset();
    while (cyc < 90) begin
      if (cyc == 6) stc = 6'd17;
      tick_cycle();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL midchg cyc=%0d got=%h exp=%h", cyc - 1, obs, exp_v);
      end
    end
    npulse = 0;
    for (int i = 1; i < 84; i++) npulse += fin_log[i];
    vectors++;
    if (fin_log[14] !== 1'b1 || fin_log[84] !== 1'b1 || npulse != 1) begin
      miscompares++;
      $display("FAIL midchg_pulses got c14=%b c84=%b n=%0d exp c14=1 c84=1 n=1", fin_log[14], fin_log[84], npulse);
    end
  endtask

  task automatic test_disable();
    int npulse;
    enable_general = 1'b1; stc = 6'd3;
    do_reset();
    while (cyc < 40) begin
      if (cyc == 8)  enable_general = 1'b0;
      if (cyc == 20) enable_general = 1'b1;
      tick_cycle();
      vectors++;
      if (obs !== exp_v || (cyc - 1 == 9 && obs !== '0)) begin
        miscompares++;
        $display("FAIL disable cyc=%0d got=%h exp=%h", cyc - 1, obs, exp_v);
      end
    end
    npulse = 0;
    for (int i = 1; i < 21; i++) npulse += fin_log[i];
    vectors++;
    if (fin_log[21] !== 1'b1 || fin_log[35] !== 1'b1 || npulse != 0) begin
      miscompares++;
      $display("FAIL disable_pulses got c21=%b c35=%b early=%0d exp 1 1 0", fin_log[21], fin_log[35], npulse);
    end
  endtask

  task automatic test_async_reset();
    enable_general = 1'b1; stc = 6'd3;
    do_reset();
    while (cyc < 8) tick_cycle();
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({finished, busy, seconds_left} !== {2'b10, SW'(0)}) begin
      miscompares++;
      $display("FAIL async_reset got=%h exp=%h", {finished, busy, seconds_left}, {2'b10, SW'(0)});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      tick_cycle();
      vectors++;
      if (obs !== exp_v || (i == 14 && obs[SW+1] !== 1'b1)) begin
        miscompares++;
        $display("FAIL async_restart cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_max_phase();
    enable_general = 1'b1; stc = 6'd63;
    do_reset();
    while (cyc < 260) begin
      tick_cycle();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL max cyc=%0d got=%h exp=%h", cyc - 1, obs, exp_v);
      end
    end
    vectors++;
    if (fin_log[254] !== 1'b1 || fin_log[253] !== 1'b0) begin
      miscompares++;
      $display("FAIL max_pulse got c253=%b c254=%b exp 0 1", fin_log[253], fin_log[254]);
    end
  endtask

  task automatic test_random();
    enable_general = 1'b1; stc = 6'd2;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 3 == 0) stc = SW'($urandom_range(0, 5));
      if ($urandom % 40 == 0) enable_general = ~enable_general;
      if ($urandom % 400 == 0) do_reset();
      tick_cycle();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int tbl [11] = '{17, 3, 1, 55, 3, 1, 27, 3, 1, 24, 3};
    int idx, last, gap, budget;
    enable_general = 1'b1; stc = 6'd0;
    do_reset();
    idx = 0; last = -1; gap = 0; budget = 0;
    while (idx < 23 && budget < 3000) begin
      tick_cycle();
      budget++;
      if (obs[SW+1]) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - 1 - last != gap) begin
            miscompares++;
            $display("FAIL system phase=%0d got gap=%0d exp gap=%0d", idx, cyc - 1 - last, gap);
          end
        end
        stc  = SW'(tbl[idx % 11]);
        gap  = tbl[idx % 11] * HZ + 2;
        last = cyc - 1;
        idx++;
      end
    end
    vectors++;
    if (idx < 23) begin
      miscompares++;
      $display("FAIL system_timeout got pulses=%0d exp pulses=23", idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_zero_phase();
    test_mid_change();
    test_disable();
    test_async_reset();
    test_max_phase();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
